multicycle_control: RTL

Multicycle control unit and program counter for the 16-bit datapath (`newStep3`). Owns PC, sequences fetch/decode/execute/memory/writeback as a Moore FSM, and drives every control input of the datapath (ALU selects, register write, immediate format, IR write, memory enables, address and write-back muxes). Consumes `Op`, immediate and compare result back from the datapath, closing the control loop.

---
 rtl/multicycle_control_if.sv | 32 +++
 rtl/multicycle_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the 16-bit multicycle machine: decode feedback in,
// control selects and PC out. master = control unit, slave = datapath.
interface multicycle_control_if;
    logic [3:0]  Op;
    logic [15:0] imm;
    logic        cmpEq;
    logic [15:0] PC;
    logic [2:0]  ALUOp;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic        writeEnable;
    logic [1:0]  immShift;
    logic [1:0]  numBits;
    logic        IRWrite;
    logic        memEnableRead;
    logic        memEnableWrite;
    logic        memAddrSel;
    logic [2:0]  regDataWrite;
    logic        halted;

    modport master (
        input  Op, imm, cmpEq,
        output PC, ALUOp, ALUSrcA, ALUSrcB, writeEnable, immShift, numBits,
        output IRWrite, memEnableRead, memEnableWrite, memAddrSel, regDataWrite, halted
    );

    modport slave (
        output Op, imm, cmpEq,
        input  PC, ALUOp, ALUSrcA, ALUSrcB, writeEnable, immShift, numBits,
        input  IRWrite, memEnableRead, memEnableWrite, memAddrSel, regDataWrite, halted
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle Moore control FSM and PC for the 16-bit datapath; outputs are registered.
// Define HALT_ON_ILLEGAL_EN to halt on opcodes C-E instead of treating them as NOPs.
module multicycle_control #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input logic                  CLK,
    input logic                  reset,
    multicycle_control_if.master bus
);

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpAnd  = 4'h2;
    localparam logic [3:0] OpOr   = 4'h3;
    localparam logic [3:0] OpAddi = 4'h4;
    localparam logic [3:0] OpLui  = 4'h5;
    localparam logic [3:0] OpLw   = 4'h6;
    localparam logic [3:0] OpSw   = 4'h7;
    localparam logic [3:0] OpBeq  = 4'h8;
    localparam logic [3:0] OpBne  = 4'h9;
    localparam logic [3:0] OpJal  = 4'hA;
    localparam logic [3:0] OpSlt  = 4'hB;
    localparam logic [3:0] OpHalt = 4'hF;

    typedef enum logic [3:0] {
        StIdle, StF0, StF1, StDec, StExecR, StExecI, StWbAlu, StWbImm,
        StMemAddr, StMemRd, StMemWait, StWbMem, StMemWr, StBranch, StJump, StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [3:0]  op_q, op_dec;
    logic        taken;

    logic [2:0]  alu_op_q, alu_op_d;
    logic        src_a_q, src_a_d;
    logic        src_b_q, src_b_d;
    logic        we_q, we_d;
    logic [1:0]  imm_shift_q, imm_shift_d;
    logic [1:0]  num_bits_q, num_bits_d;
    logic        ir_write_q, ir_write_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        addr_sel_q, addr_sel_d;
    logic [2:0]  rdw_q, rdw_d;
    logic        halted_q, halted_d;

    // Op is trusted only while in DEC; later states use the copy latched there.
    assign op_dec = (state_q == StDec) ? bus.Op : op_q;
    assign taken  = ((op_q == OpBeq) && bus.cmpEq) || ((op_q == OpBne) && !bus.cmpEq);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle:  state_d = StF0;
            StF0:    state_d = StF1;
            StF1:    state_d = StDec;
            StDec: begin
                pc_d = pc_q + 16'd2;
                unique case (bus.Op)
                    OpAdd, OpSub, OpAnd, OpOr, OpSlt: state_d = StExecR;
                    OpAddi:                           state_d = StExecI;
                    OpLui:                            state_d = StWbImm;
                    OpLw, OpSw:                       state_d = StMemAddr;
                    OpBeq, OpBne:                     state_d = StBranch;
                    OpJal:                            state_d = StJump;
                    OpHalt:                           state_d = StHalt;
                    default: begin
`ifdef HALT_ON_ILLEGAL_EN
                        state_d = StHalt;
`else
                        state_d = StF0;
`endif
                    end
                endcase
            end
            StExecR, StExecI:                 state_d = StWbAlu;
            StWbAlu, StWbImm, StWbMem, StMemWr: state_d = StF0;
            StMemAddr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWait;
            StMemWait: state_d = StWbMem;
            StBranch: begin
                if (taken) pc_d = pc_q + bus.imm;
                state_d = StF0;
            end
            StJump: begin
                pc_d    = pc_q + bus.imm;
                state_d = StF0;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the state being entered so they register alongside it.
    always_comb begin
        alu_op_d    = 3'd0;
        src_a_d     = 1'b0;
        src_b_d     = 1'b0;
        we_d        = 1'b0;
        imm_shift_d = 2'd0;
        num_bits_d  = 2'd0;
        ir_write_d  = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        addr_sel_d  = 1'b0;
        rdw_d       = 3'd0;
        halted_d    = 1'b0;
        unique case (state_d)
            StF1: ir_write_d = 1'b1;
            StExecR: begin
                src_a_d  = 1'b1;
                alu_op_d = (op_dec == OpSlt) ? 3'd1 : {1'b0, op_dec[1:0]};
            end
            StExecI: begin
                src_a_d = 1'b1;
                src_b_d = 1'b1;
            end
            StWbAlu: begin
                we_d  = 1'b1;
                rdw_d = (op_dec == OpSlt) ? 3'd4 : 3'd0;
            end
            StWbImm: begin
                we_d  = 1'b1;
                rdw_d = 3'd3;
            end
            StMemAddr: begin
                src_a_d    = 1'b1;
                src_b_d    = 1'b1;
                addr_sel_d = 1'b1;
            end
            StMemRd, StMemWait: begin
                addr_sel_d = 1'b1;
                mem_rd_d   = 1'b1;
            end
            StWbMem: begin
                we_d  = 1'b1;
                rdw_d = 3'd1;
            end
            StMemWr: begin
                addr_sel_d = 1'b1;
                mem_wr_d   = 1'b1;
            end
            StBranch: begin
                src_a_d  = 1'b1;
                alu_op_d = 3'd1;
            end
            StJump: begin
                we_d  = 1'b1;
                rdw_d = 3'd2;
            end
            StHalt:  halted_d = 1'b1;
            default: ;
        endcase

        unique case (state_d)
            StExecR, StExecI, StWbAlu, StWbImm, StMemAddr, StMemRd, StMemWait,
            StWbMem, StMemWr, StBranch, StJump: begin
                unique case (op_dec)
                    OpLui: begin
                        num_bits_d  = 2'd1;
                        imm_shift_d = 2'd1;
                    end
                    OpBeq, OpBne: num_bits_d = 2'd1;
                    OpJal:        num_bits_d = 2'd2;
                    default:      ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            pc_q        <= PC_RESET;
            op_q        <= 4'd0;
            alu_op_q    <= 3'd0;
            src_a_q     <= 1'b0;
            src_b_q     <= 1'b0;
            we_q        <= 1'b0;
            imm_shift_q <= 2'd0;
            num_bits_q  <= 2'd0;
            ir_write_q  <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            addr_sel_q  <= 1'b0;
            rdw_q       <= 3'd0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            op_q        <= op_dec;
            alu_op_q    <= alu_op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            we_q        <= we_d;
            imm_shift_q <= imm_shift_d;
            num_bits_q  <= num_bits_d;
            ir_write_q  <= ir_write_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            addr_sel_q  <= addr_sel_d;
            rdw_q       <= rdw_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.PC             = pc_q;
    assign bus.ALUOp          = alu_op_q;
    assign bus.ALUSrcA        = src_a_q;
    assign bus.ALUSrcB        = src_b_q;
    assign bus.writeEnable    = we_q;
    assign bus.immShift       = imm_shift_q;
    assign bus.numBits        = num_bits_q;
    assign bus.IRWrite        = ir_write_q;
    assign bus.memEnableRead  = mem_rd_q;
    assign bus.memEnableWrite = mem_wr_q;
    assign bus.memAddrSel     = addr_sel_q;
    assign bus.regDataWrite   = rdw_q;
    assign bus.halted         = halted_q;

endmodule
